// File: rtl/spi_share_arb_if.sv
// Requester-side and spi-master-side signals of the shared SPI arbiter.
// The arbiter takes the slave modport; the surrounding system takes master.
interface spi_share_arb_if #(
    parameter int NREQ = 3,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic               m_ss;
    logic [DW-1:0]      m_rdata;
    logic [DW-1:0]      m_data;
    logic [31:0]        m_nb_wr;

    modport slave (
        input  req, wdata, m_ss, m_rdata,
        output gnt, done, err, rdata, busy, m_data, m_nb_wr
    );

    modport master (
        output req, wdata, m_ss, m_rdata,
        input  gnt, done, err, rdata, busy, m_data, m_nb_wr
    );
endinterface

// File: rtl/spi_share_arb.sv
// Round-robin arbiter and transaction sequencer sharing one spi master
// between NREQ word-oriented requesters.
module spi_share_arb #(
    parameter int NREQ    = 3,
    parameter int DW      = 16,
    parameter int NBYTE   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_share_arb_if.slave bus
);
    localparam int                PW       = $clog2(NREQ);
    localparam int                CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]     CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]     PTR_RST  = PW'(NREQ - 1);
    localparam logic [NREQ-1:0]   GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [31:0]       NB_ARM   = 32'(NBYTE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_XFER = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t            state_r;
    logic [PW-1:0]     ptr_r;
    logic [CW-1:0]     cnt_r;
    logic [NREQ-1:0]   gnt_r;
    logic [NREQ-1:0]   done_r;
    logic              err_r;
    logic [DW-1:0]     rdata_r;
    logic              busy_r;
    logic [DW-1:0]     m_data_r;
    logic [31:0]       m_nb_wr_r;

    logic [PW:0]       wrap_s;
    logic [PW-1:0]     sel_s;
    logic              sel_vld_s;
    logic [DW-1:0]     sel_word_s;

    // Round-robin pick: scan far-to-near from ptr+1 so the nearest requester is written last and wins.
    always_comb begin
        sel_s     = ptr_r;
        sel_vld_s = 1'b0;
        wrap_s    = '0;
        for (int i = NREQ; i >= 32'sd1; i--) begin
            wrap_s    = {1'b0, ptr_r} + (PW+1)'(i);
            wrap_s    = (wrap_s >= (PW+1)'(NREQ)) ? (wrap_s - (PW+1)'(NREQ)) : wrap_s;
            sel_s     = bus.req[wrap_s[PW-1:0]] ? wrap_s[PW-1:0] : sel_s;
            sel_vld_s = sel_vld_s | bus.req[wrap_s[PW-1:0]];
        end
    end

    // Write word of the selected requester.
    always_comb begin
        sel_word_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel_word_s = (sel_s == PW'(k)) ? bus.wdata[k*DW +: DW] : sel_word_s;
        end
    end

    // Transfer sequencer: grant, arm the master, follow slave-select, report completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= PTR_RST;
            cnt_r     <= '0;
            gnt_r     <= '0;
            done_r    <= '0;
            err_r     <= 1'b0;
            rdata_r   <= '0;
            busy_r    <= 1'b0;
            m_data_r  <= '0;
            m_nb_wr_r <= 32'd0;
        end else begin
            done_r <= '0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A low slave-select here belongs to someone else's frame (or one cut by reset).
                    if (sel_vld_s && bus.m_ss) begin
                        gnt_r     <= GNT_ONE << sel_s;
                        m_data_r  <= sel_word_s;
                        m_nb_wr_r <= NB_ARM;
                        ptr_r     <= sel_s;
                        cnt_r     <= '0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_ARM;
                    end else begin
                        gnt_r <= '0;
                    end
                end
                ST_ARM: begin
                    if (!bus.m_ss) begin
                        m_nb_wr_r <= 32'd0;
                        state_r   <= ST_XFER;
                    end else if (cnt_r == CNT_LAST) begin
                        m_nb_wr_r <= 32'd0;
                        err_r     <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
                    end
                end
                ST_XFER: begin
                    if (bus.m_ss) begin
                        rdata_r <= bus.m_rdata;
                        state_r <= ST_FIN;
                    end else begin
                        state_r <= ST_XFER;
                    end
                end
                ST_FIN: begin
                    done_r  <= gnt_r;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt_r     <= '0;
                    busy_r    <= 1'b0;
                    m_nb_wr_r <= 32'd0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.rdata   = rdata_r;
    assign bus.busy    = busy_r;
    assign bus.m_data  = m_data_r;
    assign bus.m_nb_wr = m_nb_wr_r;
endmodule
